// File: rtl/acc_cpu_sequencer.sv
// Multi-cycle IDLE/FETCH/EXEC/WB control sequencer for the 8-bit accumulator CPU.
// Optional retired-instruction counter enabled by defining RETIRE_COUNT_EN.
module acc_cpu_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0,
    parameter int         OPW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    input  logic [7:0]  instr,
    input  logic        z_flag,
    output logic [7:0]  ir_out,
    output logic        pc_en,
    output logic        pc_jump,
    output logic [3:0]  jump_addr,
    output logic        mem_we,
    output logic [1:0]  acc_sel,
    output logic        acc_en,
    output logic        reg_en,
    output logic [3:0]  alu_sel,
    output logic        z_en,
`ifdef RETIRE_COUNT_EN
    output logic [15:0] retired,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_e;

    typedef enum logic [OPW-1:0] {
        OP_NOP, OP_LDAC, OP_STAC, OP_MVAC, OP_MOVR, OP_JUMP, OP_JMPZ, OP_JPNZ,
        OP_ADD, OP_SUB, OP_INAC, OP_CLAC, OP_AND, OP_OR, OP_XOR, OP_NOT
    } opcode_e;

    state_e  state, state_next;
    logic [7:0] ir;
    opcode_e opcode;

    assign opcode    = opcode_e'(ir[7:8-OPW]);
    assign ir_out    = ir;
    // Before any instruction has been fetched the PC should see the reset vector.
    assign jump_addr = (state == IDLE) ? RESET_PC : ir[3:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ir    <= 8'h00;
        end else begin
            state <= state_next;
            if (state == FETCH)
                ir <= instr;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        pc_jump    = 1'b0;
        mem_we     = 1'b0;
        acc_sel    = 2'b00;
        acc_en     = 1'b0;
        reg_en     = 1'b0;
        alu_sel    = 4'h0;
        z_en       = 1'b0;
        halted     = 1'b0;

        case (state)
            IDLE: begin
                halted = 1'b1;
                if (run || step)
                    state_next = FETCH;
            end
            FETCH: state_next = EXEC;
            EXEC: begin
                state_next = run ? FETCH : IDLE;
                case (opcode)
                    OP_NOP:  pc_en = 1'b1;
                    OP_LDAC: state_next = WB;
                    OP_STAC: begin
                        mem_we = 1'b1;
                        pc_en  = 1'b1;
                    end
                    OP_MVAC: begin
                        reg_en = 1'b1;
                        pc_en  = 1'b1;
                    end
                    OP_MOVR: begin
                        acc_sel = 2'b10;
                        acc_en  = 1'b1;
                        pc_en   = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_en   = 1'b1;
                        pc_jump = 1'b1;
                    end
                    OP_JMPZ: begin
                        pc_en   = 1'b1;
                        pc_jump = z_flag;
                    end
                    OP_JPNZ: begin
                        pc_en   = 1'b1;
                        pc_jump = ~z_flag;
                    end
                    default: begin
                        // ALU group 8..F maps onto ALU op codes 1..8.
                        alu_sel = 4'(opcode - opcode_e'(7));
                        acc_en  = 1'b1;
                        z_en    = 1'b1;
                        pc_en   = 1'b1;
                    end
                endcase
            end
            WB: begin
                acc_sel    = 2'b01;
                acc_en     = 1'b1;
                pc_en      = 1'b1;
                state_next = run ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RETIRE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            retired <= 16'h0000;
        else if (pc_en)
            retired <= retired + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Directed self-checking bench for acc_cpu_sequencer; define RETIRE_COUNT_EN to
// also check the retired-instruction counter.
module tb_acc_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic [7:0]  instr;
    logic        z_flag;
    logic [7:0]  ir_out;
    logic        pc_en, pc_jump, mem_we, acc_en, reg_en, z_en, halted;
    logic [3:0]  jump_addr, alu_sel;
    logic [1:0]  acc_sel;
`ifdef RETIRE_COUNT_EN
    logic [15:0] retired;
`endif

    int total = 0;
    int bad   = 0;

    acc_cpu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .instr     (instr),
        .z_flag    (z_flag),
        .ir_out    (ir_out),
        .pc_en     (pc_en),
        .pc_jump   (pc_jump),
        .jump_addr (jump_addr),
        .mem_we    (mem_we),
        .acc_sel   (acc_sel),
        .acc_en    (acc_en),
        .reg_en    (reg_en),
        .alu_sel   (alu_sel),
        .z_en      (z_en),
`ifdef RETIRE_COUNT_EN
        .retired   (retired),
`endif
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packs the control outputs in a fixed order for one-shot comparison.
    function automatic logic [15:0] ctl(input logic pe, input logic pj, input logic we,
                                        input logic [1:0] as, input logic ae, input logic re,
                                        input logic [3:0] al, input logic ze, input logic h);
        return {3'b000, pe, pj, we, as, ae, re, al, ze, h};
    endfunction

    function automatic logic [15:0] ctl_dut();
        return {3'b000, pc_en, pc_jump, mem_we, acc_sel, acc_en, reg_en, alu_sel, z_en, halted};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-steps one non-LDAC instruction from IDLE and checks its EXEC decode.
    task automatic step_one(input string tag, input logic [7:0] op, input logic [15:0] exp_ctl,
                            input logic [3:0] exp_ja);
        instr = op;
        step  = 1'b1;
        tick();                       // FETCH
        step  = 1'b0;
        tick();                       // EXEC
        check({tag, "_ir"},  16'(ir_out), 16'(op));
        check({tag, "_ctl"}, ctl_dut(), exp_ctl);
        check({tag, "_ja"},  16'(jump_addr), 16'(exp_ja));
        tick();                       // back to IDLE
        check({tag, "_idle"}, ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
    endtask

    initial begin
        reset  = 1'b1;
        run    = 1'b1;
        step   = 1'b0;
        instr  = 8'h1A;
        z_flag = 1'b0;

        // Reset held with run=1: stays IDLE, everything quiet.
        #3;
        check("rst_ctl", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
        check("rst_ir",  16'(ir_out), 16'h0000);
        check("rst_ja",  16'(jump_addr), 16'h0000);
        tick();
        check("rst_hold", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
        reset = 1'b0;

        // LDAC 0xA: FETCH, EXEC (no enables), WB.
        tick();
        check("ldac_fetch", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,0));
        tick();
        check("ldac_ir",   16'(ir_out), 16'h001A);
        check("ldac_exec", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,0));
        check("ldac_ja",   16'(jump_addr), 16'h000A);
        instr = 8'h83;
        tick();
        check("ldac_wb",   ctl_dut(), ctl(1,0,0,2'b01,1,0,4'h0,0,0));

        // ADD 3 straight after, run still high.
        tick();
        check("add_fetch", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,0));
        tick();
        check("add_exec",  ctl_dut(), ctl(1,0,0,2'b00,1,0,4'h1,1,0));

        // JMPZ 5: pc_jump follows z_flag within the EXEC cycle.
        instr  = 8'h65;
        z_flag = 1'b1;
        tick();
        tick();
        check("jmpz_z1", ctl_dut(), ctl(1,1,0,2'b00,0,0,4'h0,0,0));
        check("jmpz_ja", 16'(jump_addr), 16'h0005);
        z_flag = 1'b0;
        #1;
        check("jmpz_z0", ctl_dut(), ctl(1,0,0,2'b00,0,0,4'h0,0,0));

        // JPNZ 5: inverse sense.
        instr  = 8'h75;
        z_flag = 1'b1;
        tick();
        tick();
        check("jpnz_z1", ctl_dut(), ctl(1,0,0,2'b00,0,0,4'h0,0,0));
        z_flag = 1'b0;
        #1;
        check("jpnz_z0", ctl_dut(), ctl(1,1,0,2'b00,0,0,4'h0,0,0));

        // NOT with run dropping during FETCH: instruction completes, then IDLE.
        instr = 8'hF0;
        tick();
        run = 1'b0;
        tick();
        check("not_exec", ctl_dut(), ctl(1,0,0,2'b00,1,0,4'h8,1,0));
        tick();
        check("runfall_idle", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
        tick();
        check("idle_stays", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
`ifdef RETIRE_COUNT_EN
        check("retired_5", retired, 16'd5);
`endif

        // Single step of STAC 3; a step pulse during EXEC must be ignored.
        instr = 8'h23;
        step  = 1'b1;
        tick();
        step  = 1'b0;
        check("stac_fetch", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,0));
        tick();
        check("stac_exec", ctl_dut(), ctl(1,0,1,2'b00,0,0,4'h0,0,0));
        step = 1'b1;
        tick();
        step = 1'b0;
        check("stac_idle", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
        tick();
        check("step_ignored", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));

        // Remaining opcode classes, one step each.
        step_one("mvac", 8'h37, ctl(1,0,0,2'b00,0,1,4'h0,0,0), 4'h7);
        step_one("movr", 8'h48, ctl(1,0,0,2'b10,1,0,4'h0,0,0), 4'h8);
        step_one("jump", 8'h5C, ctl(1,1,0,2'b00,0,0,4'h0,0,0), 4'hC);
        step_one("nop",  8'h00, ctl(1,0,0,2'b00,0,0,4'h0,0,0), 4'h0);
        step_one("clac", 8'hB1, ctl(1,0,0,2'b00,1,0,4'h4,1,0), 4'h1);
        step_one("sub",  8'h92, ctl(1,0,0,2'b00,1,0,4'h2,1,0), 4'h2);
`ifdef RETIRE_COUNT_EN
        check("retired_12", retired, 16'd12);
`endif

        // run and step together behave as run; then reset lands in STAC EXEC.
        run   = 1'b1;
        step  = 1'b1;
        instr = 8'h23;
        tick();
        step  = 1'b0;
        check("runstep_fetch", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,0));
        tick();
        check("runstep_exec", ctl_dut(), ctl(1,0,1,2'b00,0,0,4'h0,0,0));
        reset = 1'b1;
        #1;
        check("rst_exec_ctl", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
        check("rst_exec_ir",  16'(ir_out), 16'h0000);
`ifdef RETIRE_COUNT_EN
        check("rst_exec_retired", retired, 16'd0);
`endif
        tick();
        check("rst_exec_hold", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));
        run   = 1'b0;
        reset = 1'b0;
        tick();
        check("post_rst_idle", ctl_dut(), ctl(0,0,0,2'b00,0,0,4'h0,0,1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit accumulator datapath: PC, shared data/instruction memory, 3:1 accumulator mux, ALU, accumulator, R register and Z flag flip-flop.
- Replaces the single-cycle combinational decoder.
- Latches the fetched instruction into an internal IR, then sequences FETCH/EXEC/WB states.
- Adds run/single-step control, so every datapath register updates only under an explicit enable.

Parameters:
- RESET_PC, 4'h0, value driven on jump_addr while in IDLE after reset.
- OPW, 4, opcode field width (instr[7:4]); the address field is instr[3:0].

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = execute continuously
- step  in  1  one-cycle pulse; executes exactly one instruction from IDLE
- instr  in  8  memory instruction-read data at the current PC
- z_flag  in  1  registered Z flag from the datapath
- ir_out  out  8  latched instruction register
- pc_en  out  1  PC flip-flop load enable
- pc_jump  out  1  1 = PC loads jump_addr; 0 = PC loads PC+1
- jump_addr  out  4  ir_out[3:0]
- mem_we  out  1  data-memory write (address ir_out[3:0], data = AC)
- acc_sel  out  2  accumulator mux select: 00 ALU, 01 memory RD, 10 R
- acc_en  out  1  accumulator load enable
- reg_en  out  1  R register load enable
- alu_sel  out  4  ALU operation select
- z_en  out  1  Z flag flip-flop load enable
- halted  out  1  1 while in IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, IR = 8'h00.
  - All enables, mem_we, pc_jump and acc_sel go to 0 immediately (combinational decode of state).
  - halted = 1.
- All outputs are Moore-decoded from state and IR. No output depends combinationally on run or step.
- States and transitions:
  - IDLE: leave to FETCH if run=1, or if step=1 (step is sampled only in IDLE; ignored elsewhere).
  - FETCH: IR <= instr. No datapath enables asserted. Next state EXEC.
  - EXEC: decode IR[7:4]:
    - 0 NOP: pc_en.
    - 1 LDAC: no enables. Memory read address = IR[3:0]. Next state WB.
    - 2 STAC: mem_we=1, pc_en.
    - 3 MVAC: reg_en=1, pc_en.
    - 4 MOVR: acc_sel=10, acc_en=1, pc_en.
    - 5 JUMP: pc_en=1, pc_jump=1.
    - 6 JMPZ: pc_en=1, pc_jump=z_flag.
    - 7 JPNZ: pc_en=1, pc_jump=~z_flag.
    - 8–F ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT: alu_sel = IR[7:4]-7 (1..8), acc_sel=00, acc_en=1, z_en=1, pc_en.
  - WB (LDAC only): acc_sel=01, acc_en=1, pc_en=1.
- After EXEC (non-LDAC) or WB, next state is FETCH if run=1, else IDLE.
- CPI: 2 cycles for all instructions except LDAC, which takes 3.
- alu_sel = 0 outside ALU-op EXEC cycles.
- Z flag is written only by ALU ops. Branches use the z_flag value present in their EXEC cycle.
- Boundary conditions:
  - run falling mid-instruction: the instruction completes, then the FSM enters IDLE.
  - run and step both high in IDLE: behaves as run.
  - Reset during EXEC of STAC: no memory write occurs after reset assertion.
  - PC wrap 4'hF -> 4'h0 is handled by the PC adder; no special handling in the sequencer.
  - Every opcode 0–F is defined; there is no illegal-opcode state.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- When defined: adds output port retired, 16 bits, counting completed instructions. It increments in the cycle pc_en=1, wraps at 16'hFFFF -> 0, and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with run=1 -> halted=1, all enables 0. Release reset -> FETCH next cycle, ir_out=instr one cycle later.
- run=1, program 8'h1A (LDAC 0xA) -> EXEC with no enables, then WB with acc_sel=01, acc_en=1, pc_en=1. Total 3 cycles.
- IR=8'h8x (ADD) -> EXEC: alu_sel=4'b0001, acc_en=1, z_en=1, pc_en=1, pc_jump=0.
- JMPZ 8'h65 with z_flag=1 -> pc_jump=1, jump_addr=4'h5. Same instruction with z_flag=0 -> pc_jump=0. JPNZ 8'h75 -> the inverse.
- run=0, single step pulse in IDLE on STAC 8'h23 -> mem_we=1 for exactly one cycle, then IDLE, halted=1. A step pulse while in EXEC is ignored.
- With RETIRE_COUNT_EN: execute 5 instructions -> retired=5. Assert reset during STAC EXEC -> mem_we drops to 0 the same cycle and retired=0.
